// File: rtl/tmma_sequencer.sv
// tmma_sequencer: buffers issued tmma ops and streams each one as per-row operand reads
// with an optional accumulator clear, a pipeline drain wait and a completion pulse.
`ifndef TINST_TYPE_WIDTH
`define TINST_TYPE_WIDTH 4
`endif
`ifndef TLOAD_DATAW_WIDTH
`define TLOAD_DATAW_WIDTH 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 3
`endif

module tmma_sequencer #(
    parameter int FIFO_DEPTH   = 2,
    parameter int TILE_ROWS    = 8,
    parameter int ROW_STRIDE   = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int TMMA_TYPE    = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             issue_tmma_valid_i,
    output logic                             issue_tmma_ready_o,
    input  logic [`TINST_TYPE_WIDTH-1:0]     issue_tmma_type_i,
    input  logic [`TLOAD_DATAW_WIDTH-1:0]    issue_tmma_data_width_i,
    input  logic [`ADDR_WIDTH-1:0]           issue_tmma_addr0_i,
    input  logic [`ADDR_WIDTH-1:0]           issue_tmma_addr1_i,
    input  logic [`TMMA_PRECISION_WIDTH-1:0] issue_tmma_precision_i,
    input  logic                             issue_tmma_acc_i,
    output logic                             arr_acc_clr_o,
    output logic                             arr_rd_vld_o,
    input  logic                             arr_rd_rdy_i,
    output logic [`ADDR_WIDTH-1:0]           arr_rd_addr0_o,
    output logic [`ADDR_WIDTH-1:0]           arr_rd_addr1_o,
    output logic                             arr_rd_last_o,
    output logic [`TMMA_PRECISION_WIDTH-1:0] arr_prec_o,
    output logic [`TLOAD_DATAW_WIDTH-1:0]    arr_dw_o,
    output logic                             tmma_done_o,
    output logic                             tmma_err_o,
    output logic                             tmma_busy_o
);
    localparam int TW   = `TINST_TYPE_WIDTH;
    localparam int DWW  = `TLOAD_DATAW_WIDTH;
    localparam int AW   = `ADDR_WIDTH;
    localparam int PRW  = `TMMA_PRECISION_WIDTH;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int ROWW = TILE_ROWS > 1 ? $clog2(TILE_ROWS) : 1;
    localparam int DRW  = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    localparam int OPW  = TW + DWW + 2 * AW + PRW + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [OPW-1:0]  mem [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [PTRW:0]   count;
    logic [ROWW-1:0] row;
    logic [DRW-1:0]  drain_cnt;
    logic            act_err;
    logic [TW-1:0]   head_type;
    logic [DWW-1:0]  head_dw;
    logic [AW-1:0]   head_a0, head_a1;
    logic [PRW-1:0]  head_prec;
    logic            head_acc;
    logic            push, pop, accept, last;

    assign {head_type, head_dw, head_a0, head_a1, head_prec, head_acc} = mem[rd_ptr];
    assign issue_tmma_ready_o = count != (PTRW + 1)'(FIFO_DEPTH);
    assign push   = issue_tmma_valid_i & issue_tmma_ready_o;
    assign pop    = state == IDLE && count != '0;
    assign accept = arr_rd_vld_o & arr_rd_rdy_i;
    assign last   = row == ROWW'(TILE_ROWS - 1);

    assign arr_acc_clr_o = state == CLEAR;
    assign arr_rd_vld_o  = state == STREAM;
    assign arr_rd_last_o = arr_rd_vld_o & last;
    assign tmma_done_o   = state == DONE;
    assign tmma_err_o    = tmma_done_o & act_err;
    assign tmma_busy_o   = state != IDLE || count != '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (pop) state_nx = head_type != TW'(TMMA_TYPE) ? DONE : !head_acc ? CLEAR : STREAM;
            CLEAR:  state_nx = STREAM;
            STREAM: if (accept && last) state_nx = DRAIN_CYCLES == 0 ? DONE : DRAIN;
            DRAIN:  if (drain_cnt == DRW'(DRAIN_CYCLES - 1)) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {issue_tmma_type_i, issue_tmma_data_width_i, issue_tmma_addr0_i,
                                  issue_tmma_addr1_i, issue_tmma_precision_i, issue_tmma_acc_i};
    end

    // Row addresses advance by a running add rather than base + row*stride.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            row            <= '0;
            drain_cnt      <= '0;
            act_err        <= 1'b0;
            arr_prec_o     <= '0;
            arr_dw_o       <= '0;
            arr_rd_addr0_o <= '0;
            arr_rd_addr1_o <= '0;
        end else begin
            state     <= state_nx;
            wr_ptr    <= wr_ptr + PTRW'(push);
            rd_ptr    <= rd_ptr + PTRW'(pop);
            count     <= count + (PTRW + 1)'(push) - (PTRW + 1)'(pop);
            drain_cnt <= state == DRAIN ? drain_cnt + DRW'(1) : '0;
            if (pop) begin
                act_err        <= head_type != TW'(TMMA_TYPE);
                arr_prec_o     <= head_prec;
                arr_dw_o       <= head_dw;
                arr_rd_addr0_o <= head_a0;
                arr_rd_addr1_o <= head_a1;
                row            <= '0;
            end else if (accept) begin
                arr_rd_addr0_o <= arr_rd_addr0_o + AW'(ROW_STRIDE);
                arr_rd_addr1_o <= arr_rd_addr1_o + AW'(ROW_STRIDE);
                row            <= row + ROWW'(1);
            end
        end
    end
endmodule

// File: tb/tb_tmma_sequencer.sv
// tb_tmma_sequencer: directed checks of the tmma sequencer with default parameters.
`ifndef TINST_TYPE_WIDTH
`define TINST_TYPE_WIDTH 4
`endif
`ifndef TLOAD_DATAW_WIDTH
`define TLOAD_DATAW_WIDTH 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 3
`endif

module tb_tmma_sequencer;
    logic        clk = 0, rst_n = 0;
    logic        valid = 0, ready, acc = 0, clr, vld, rdy = 0, last, done, err, busy;
    logic [3:0]  typ = 0;
    logic [1:0]  dw = 0, dw_o;
    logic [2:0]  prec = 0, prec_o;
    logic [31:0] a0 = 0, a1 = 0, ra0, ra1;
    int          checks = 0, errors = 0, done_cnt = 0;
    logic [31:0] last_q[$];

    tmma_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .issue_tmma_valid_i(valid), .issue_tmma_ready_o(ready),
        .issue_tmma_type_i(typ), .issue_tmma_data_width_i(dw),
        .issue_tmma_addr0_i(a0), .issue_tmma_addr1_i(a1),
        .issue_tmma_precision_i(prec), .issue_tmma_acc_i(acc),
        .arr_acc_clr_o(clr), .arr_rd_vld_o(vld), .arr_rd_rdy_i(rdy),
        .arr_rd_addr0_o(ra0), .arr_rd_addr1_o(ra1), .arr_rd_last_o(last),
        .arr_prec_o(prec_o), .arr_dw_o(dw_o),
        .tmma_done_o(done), .tmma_err_o(err), .tmma_busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vld && rdy && last) last_q.push_back(ra0);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [3:0] t, input logic [31:0] x0, input logic [31:0] x1,
                            input logic c, input logic [2:0] p, input logic [1:0] w);
        typ = t; a0 = x0; a1 = x1; acc = c; prec = p; dw = w; valid = 1;
    endtask

    task automatic push_op(input logic [3:0] t, input logic [31:0] x0, input logic [31:0] x1,
                           input logic c, input logic [2:0] p, input logic [1:0] w);
        drive_op(t, x0, x1, c, p, w);
        @(negedge clk);
        valid = 0;
    endtask

    // Called on the negedge right after the op was pushed into an empty FIFO with the FSM idle.
    task automatic run_op(input logic [31:0] x0, input logic [31:0] x1, input logic c,
                          input logic bp, input logic [2:0] p, input logic [1:0] w);
        int row, k;
        row = 0; k = 0;
        check("pre_vld", vld, 0);
        @(negedge clk);
        if (!c) begin
            check("clr_hi", clr, 1);
            check("clr_vld", vld, 0);
            @(negedge clk);
        end
        check("prec", prec_o, p);
        check("dw", dw_o, w);
        while (row < 8 && k < 100) begin
            check("vld", vld, 1);
            check("clr_lo", clr, 0);
            check("addr0", ra0, x0 + 32'(row) * 32'h40);
            check("addr1", ra1, x1 + 32'(row) * 32'h40);
            check("last", last, row == 7);
            rdy = bp ? (k % 3 == 0) : 1'b1;
            if (rdy) row++;
            k++;
            @(negedge clk);
        end
        rdy = 0;
        check("rows", row, 8);
        repeat (4) begin
            check("drain_vld", vld, 0);
            check("drain_done", done, 0);
            @(negedge clk);
        end
        check("done", done, 1);
        check("err", err, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int base_done, base_q, g;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_vld", vld, 0);
        check("rst_clr", clr, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_addr0", ra0, 0);
        rst_n = 1;
        @(negedge clk);

        push_op(4'd3, 32'h1000, 32'h2000, 1, 3'd5, 2'd2);
        run_op(32'h1000, 32'h2000, 1, 0, 3'd5, 2'd2);

        push_op(4'd3, 32'h8000, 32'h9000, 0, 3'd1, 2'd1);
        run_op(32'h8000, 32'h9000, 0, 0, 3'd1, 2'd1);

        push_op(4'd3, 32'h0A00, 32'h0B00, 1, 3'd2, 2'd3);
        run_op(32'h0A00, 32'h0B00, 1, 1, 3'd2, 2'd3);

        push_op(4'd3, 32'hFFFF_FFC0, 32'h0000_0100, 1, 3'd7, 2'd0);
        run_op(32'hFFFF_FFC0, 32'h0000_0100, 1, 0, 3'd7, 2'd0);

        // Illegal type: straight to DONE with err, no clear, no reads.
        push_op(4'd0, 32'h7000, 32'h7100, 0, 3'd4, 2'd1);
        check("err_idle_vld", vld, 0);
        @(negedge clk);
        check("err_done", done, 1);
        check("err_err", err, 1);
        check("err_vld", vld, 0);
        check("err_clr", clr, 0);
        @(negedge clk);
        check("err_done_lo", done, 0);
        check("err_err_lo", err, 0);
        check("err_busy", busy, 0);

        // FIFO full while the first op is stalled in STREAM.
        base_done = done_cnt;
        base_q = last_q.size();
        push_op(4'd3, 32'h3000, 32'h3100, 1, 3'd0, 2'd0);
        @(negedge clk);
        check("full_a_vld", vld, 1);
        drive_op(4'd3, 32'h4000, 32'h4100, 1, 3'd0, 2'd0);
        @(negedge clk);
        check("full_rdy1", ready, 1);
        drive_op(4'd3, 32'h5000, 32'h5100, 1, 3'd0, 2'd0);
        @(negedge clk);
        check("full_rdy0", ready, 0);
        drive_op(4'd3, 32'h6000, 32'h6100, 1, 3'd0, 2'd0);
        repeat (3) @(negedge clk);
        check("full_hold", ready, 0);
        check("full_busy", busy, 1);
        rdy = 1;
        g = 0;
        while (!ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("full_reopen", g < 100, 1);
        check("full_after_pop", done_cnt - base_done, 1);
        @(negedge clk);
        valid = 0;
        g = 0;
        while (done_cnt - base_done < 4 && g < 200) begin
            @(negedge clk);
            g++;
        end
        rdy = 0;
        check("full_done_cnt", done_cnt - base_done, 4);
        for (int i = 0; i < 4; i++)
            check("full_order", base_q + i < last_q.size() ? last_q[base_q + i] : 32'hDEAD_BEEF,
                  32'h3000 + 32'(i) * 32'h1000 + 32'h1C0);

        // Reset asserted mid-STREAM with another op buffered.
        @(negedge clk);
        push_op(4'd3, 32'hC000, 32'hC100, 1, 3'd3, 2'd3);
        drive_op(4'd3, 32'hD000, 32'hD100, 1, 3'd3, 2'd3);
        @(negedge clk);
        valid = 0;
        check("mid_vld", vld, 1);
        check("mid_ready", ready, 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_mid_vld", vld, 0);
        check("rst_mid_ready", ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_prec", prec_o, 0);
        base_done = done_cnt;
        @(negedge clk);
        rst_n = 1;
        repeat (15) @(negedge clk);
        check("rst_no_done", done_cnt - base_done, 0);
        check("rst_discard", busy, 0);
        check("rst_idle_vld", vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tmma_sequencer.md
# tmma_sequencer

Downstream consumer of the reservation station's tmma issue channel. It buffers issued tile matrix-multiply ops in a small FIFO and sequences each op into per-row operand read requests for the matrix array, with accumulator clear, drain wait, and a completion pulse. It sits between the reservation station and the systolic MAC array / tile SRAM read ports.

## Interface
Parameters:
- FIFO_DEPTH, 2: issue ops buffered (power of two, ≥2).
- TILE_ROWS, 8: rows streamed per op (≥1).
- ROW_STRIDE, 64: byte address increment per row.
- DRAIN_CYCLES, 4: array pipeline drain wait after last row (≥0).
- TMMA_TYPE, 3: legal value of the type field; any other value is an error op.

Ports:
- clk  in  1  clock, all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_tmma_valid_i  in  1  op valid.
- issue_tmma_ready_o  out  1  FIFO not full.
- issue_tmma_type_i  in  `TINST_TYPE_WIDTH  op type.
- issue_tmma_data_width_i  in  `TLOAD_DATAW_WIDTH  element width code.
- issue_tmma_addr0_i  in  `ADDR_WIDTH  tile A base address.
- issue_tmma_addr1_i  in  `ADDR_WIDTH  tile B base address.
- issue_tmma_precision_i  in  `TMMA_PRECISION_WIDTH  MAC precision.
- issue_tmma_acc_i  in  1  1 = accumulate onto existing C, 0 = clear C first.
- arr_acc_clr_o  out  1  one-cycle accumulator clear.
- arr_rd_vld_o  out  1  row read request valid.
- arr_rd_rdy_i  in  1  row read request accepted.
- arr_rd_addr0_o  out  `ADDR_WIDTH  A row address.
- arr_rd_addr1_o  out  `ADDR_WIDTH  B row address.
- arr_rd_last_o  out  1  current request is row TILE_ROWS-1.
- arr_prec_o  out  `TMMA_PRECISION_WIDTH  precision of active op.
- arr_dw_o  out  `TLOAD_DATAW_WIDTH  data width of active op.
- tmma_done_o  out  1  one-cycle completion pulse.
- tmma_err_o  out  1  qualifies tmma_done_o: op had illegal type.
- tmma_busy_o  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- FIFO: push on valid_i & ready_o; ready_o = (count != FIFO_DEPTH) from registered count only — a pop in the same cycle does not raise ready while full. Simultaneous push/pop when non-empty and not full: count unchanged. Pop occurs only on the IDLE→next transition.
- FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: if FIFO non-empty, pop head into active-op registers; type≠TMMA_TYPE → DONE (err); acc=0 → CLEAR; else → STREAM. Row counter reset to 0.
- CLEAR: arr_acc_clr_o=1 for exactly one cycle → STREAM.
- STREAM: arr_rd_vld_o=1; addr0_o = base0 + row*ROW_STRIDE, addr1_o = base1 + row*ROW_STRIDE, modulo 2^`ADDR_WIDTH (wrap silently). On vld&rdy, row increments; request fields held stable while rdy=0. Acceptance with last_o=1 → DRAIN (DRAIN_CYCLES=0 → DONE directly).
- DRAIN: count DRAIN_CYCLES cycles → DONE.
- DONE: tmma_done_o=1 one cycle, tmma_err_o set if illegal type → IDLE.
- arr_prec_o/arr_dw_o driven from active-op registers, held from pop until the next pop.
- Error ops issue no clear and no reads.

## Timing
- Reset (async assert): FIFO empty, FSM IDLE, row=0; all outputs 0 except issue_tmma_ready_o=1.
- Op accepted at edge T (FIFO empty, FSM IDLE): FSM leaves IDLE at edge T+1; acc=0 → clr_o high in cycle after T+1, first rd_vld one cycle later; acc=1 → first rd_vld in cycle after T+1.
- With rdy tied 1, acc=1: STREAM lasts TILE_ROWS cycles, DRAIN DRAIN_CYCLES, DONE 1, IDLE 1 → back-to-back op period TILE_ROWS+DRAIN_CYCLES+2 (+1 if acc=0).
- Error op: IDLE→DONE→IDLE, 2 cycles.
- Reset asserted mid-STREAM: vld_o drops immediately, no done pulse, buffered ops discarded.

## Test plan
- Single op, acc=1, addr0=0x1000, addr1=0x2000, rdy=1 → 8 requests, addr0 0x1000..0x11C0 step 0x40, last_o on 8th, done 4 cycles after last accept, no clr.
- acc=0 op → exactly one clr_o cycle immediately before first rd_vld.
- Backpressure: rdy toggles 1,0,0,1,… → each row issued once, addresses held across stalls, row order preserved.
- Wrap: addr0=0xFFFF_FFC0 → second row addr0=0x0000_0000.
- FIFO full: 3 ops pushed back-to-back with FSM busy → ready_o low after 2 buffered, third accepted only after a pop; all three complete in order.
- Illegal type=0 → done_o and err_o high together 2 cycles after pop decision, no rd_vld; reset mid-STREAM → all outputs 0, ready_o=1, no done.
